imm_gen_stage: RTL and testbench
================================

Name: imm_gen_stage

Overview:
- Registered immediate-generation pipeline stage between fetch and the decode/execute path.
- Accepts one instruction word per cycle over a valid/ready handshake.
- Emits the sign- or zero-extended immediate at XLEN width, plus a format tag and a pass-through iword.
- Adds to the plain combinational generator: RV64 width, shift-amount immediates, CSR zimm, backpressure with an optional skid buffer, and flush.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SKID, 1, 1 = two-entry skid buffer (in_ready is registered, full throughput under backpressure); 0 = single output register (in_ready = !out_valid || out_ready).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; drops all held and incoming entries.
- in_valid  in  1  iword valid.
- in_ready  out  1  stage can accept.
- in_iword  in  32  instruction word.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  immediate.
- out_fmt  out  3  imm_fmt_e: NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6, SH=7.
- out_iword  out  32  registered copy of the accepted iword.
- out_illegal  out  1  iword[1:0] != 2'b11.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_imm=0, out_fmt=NONE, out_iword=0, out_illegal=0, skid empty.
  - in_ready=1 from the first clock edge after reset release.
- Transfer rules:
  - Input transfer on in_valid && in_ready; output transfer on out_valid && out_ready.
  - Latency is exactly 1 cycle: accept in cycle N, out_valid in cycle N+1.
- Output hold: while out_valid && !out_ready, all out_* stay stable.
- SKID=1:
  - An accept while the output is stalled goes into the skid register, and in_ready drops the next cycle.
  - On out_ready, the skid entry moves to the output the same cycle and in_ready rises next cycle.
  - Order is preserved; no entry is lost or duplicated.
- SKID=0: in_ready is combinational from out_ready; no skid storage.
- Flush:
  - Next edge clears out_valid and skid valid.
  - An input handshake in the same cycle is discarded: flush wins.
  - in_ready is unaffected.
- Immediate rules (ext() = sign-extend iword[31] to XLEN):
  - I: opcodes 0000011, 1100111, 0010011 (non-shift), 1110011 with funct3[2]=0; immediate is ext(iword[31:20]).
  - SH: 0010011 with funct3 001/101 gives zero-extended shamt. XLEN=32 uses iword[24:20]; XLEN=64 uses iword[25:20].
  - When XLEN=64, opcode 0011011 is also valid: funct3 001/101 gives SH with iword[24:20], otherwise I.
  - Z: 1110011 with funct3[2]=1 gives zero-extended iword[19:15].
  - S: ext({iword[31:25], iword[11:7]}).
  - B: ext({iword[31], iword[7], iword[30:25], iword[11:8], 0}).
  - U: opcodes 0110111 and 0010111; ext({iword[31:12], 12'b0}). Bits 63:32 are sign copies when XLEN=64.
  - J: ext({iword[31], iword[19:12], iword[20], iword[30:21], 0}).
  - Unknown opcode: imm=0, fmt=NONE, illegal=0.
  - iword[1:0] != 11: imm=0, fmt=NONE, illegal=1.
- The combinational result is computed on in_iword and registered on accept. No combinational path runs from in_iword to out_*.

Decomposition:
- imm_pkg holds:
  - imm_fmt_e enum (3-bit).
  - Opcode localparams: OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM.
  - Function imm_sext(width-generic).
- Sub-module imm_gen_core:
  - Purely combinational, parameter XLEN.
  - iword in; imm, fmt, illegal out.
  - imm_gen_stage instantiates it plus the output/skid registers and handshake logic.

Test Plan:
1. XLEN=32, 0xFFF00093 (addi -1) accepted cycle N -> cycle N+1: out_imm=0xFFFFFFFF, fmt=I. XLEN=64, 0x800000B7 (lui) -> 0xFFFFFFFF80000000, fmt=U.
2. 0xFE20AE23 (sw x2,-4(x1)) -> 0xFFFFFFFC, fmt=S. 0x4030D093 (srai x1,x1,3) -> 0x00000003, fmt=SH (not 0x403).
3. 0x3002D073 (csrrwi x0,0x300,5) -> 0x00000005, fmt=Z. 0x30001073 (csrrw) -> 0x00000300, fmt=I. 0x00000001 -> illegal=1, imm=0.
4. SKID=1: stream A,B,C with out_ready=0 for 3 cycles -> A held stable, B in skid, in_ready=0, C not accepted. Then out_ready=1 -> A,B,C delivered in order, back-to-back.
5. Flush asserted in the same cycle as an in_valid handshake with out_valid=1 -> next cycle out_valid=0 and nothing emitted for the dropped word.
6. rst pulsed mid-cycle with out_valid=1 and skid full -> out_valid=0 and outputs zero before the next clk edge; in_ready=1 after release.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types, opcodes and helpers for the immediate-generation stage.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_SH   = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  // Per-entry metadata that travels alongside the immediate.
  typedef struct packed {
    logic [31:0] iword;
    logic        illegal;
    imm_fmt_e    fmt;
  } imm_meta_t;

  // Sign-extend the low 'width' bits (1..32) of val to 64 bits.
  function automatic logic [63:0] imm_sext(input logic [31:0] val, input int unsigned width);
    logic [63:0] r;
    r = {val, 32'b0};
    r = r << (32 - width);
    return $signed(r) >>> (64 - width);
  endfunction

endpackage

// File: rtl/imm_gen_core.sv
// Combinational immediate decoder: iword -> immediate, format tag, illegal flag.
module imm_gen_core
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     iword,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [6:0] opc;
  logic [2:0] funct3;
  logic       is_shift;

  assign opc      = iword[6:0];
  assign funct3   = iword[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Select the immediate layout from opcode/funct3 and extend to XLEN.
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (iword[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opc)
        OPC_LOAD, OPC_JALR: begin
          fmt = FMT_I;
          imm = XLEN'(imm_sext(32'(iword[31:20]), 12));
        end
        OPC_OPIMM: begin
          if (is_shift) begin
            fmt = FMT_SH;
            imm = (XLEN == 64) ? XLEN'(iword[25:20]) : XLEN'(iword[24:20]);
          end else begin
            fmt = FMT_I;
            imm = XLEN'(imm_sext(32'(iword[31:20]), 12));
          end
        end
        OPC_OPIMM32: begin
          // Word-sized ops exist only on RV64; otherwise treated as unknown.
          if (XLEN == 64) begin
            if (is_shift) begin
              fmt = FMT_SH;
              imm = XLEN'(iword[24:20]);
            end else begin
              fmt = FMT_I;
              imm = XLEN'(imm_sext(32'(iword[31:20]), 12));
            end
          end
        end
        OPC_SYSTEM: begin
          if (funct3[2]) begin
            fmt = FMT_Z;
            imm = XLEN'(iword[19:15]);
          end else begin
            fmt = FMT_I;
            imm = XLEN'(imm_sext(32'(iword[31:20]), 12));
          end
        end
        OPC_STORE: begin
          fmt = FMT_S;
          imm = XLEN'(imm_sext(32'({iword[31:25], iword[11:7]}), 12));
        end
        OPC_BRANCH: begin
          fmt = FMT_B;
          imm = XLEN'(imm_sext(32'({iword[31], iword[7], iword[30:25], iword[11:8], 1'b0}), 13));
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt = FMT_U;
          imm = XLEN'(imm_sext({iword[31:12], 12'b0}, 32));
        end
        OPC_JAL: begin
          fmt = FMT_J;
          imm = XLEN'(imm_sext(32'({iword[31], iword[19:12], iword[20], iword[30:21], 1'b0}), 21));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with valid/ready, optional skid entry and flush.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_iword,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_e        out_fmt,
  output logic [31:0]     out_iword,
  output logic            out_illegal
);

  logic [XLEN-1:0] core_imm;
  imm_fmt_e        core_fmt;
  logic            core_illegal;
  imm_meta_t       core_meta;

  imm_gen_core #(.XLEN(XLEN)) u_core (
    .iword   (in_iword),
    .imm     (core_imm),
    .fmt     (core_fmt),
    .illegal (core_illegal)
  );

  assign core_meta = '{iword: in_iword, illegal: core_illegal, fmt: core_fmt};

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  imm_meta_t       out_meta_q, out_meta_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  imm_meta_t       skid_meta_q, skid_meta_d;
  logic            ready_q;
  logic            accept;

  // With a skid entry, ready only depends on whether the skid slot is free.
  assign in_ready = (SKID != 0) ? ready_q : (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Next-state for output and skid registers; flush drops everything held or arriving.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_meta_d   = out_meta_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_meta_d  = skid_meta_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_meta_d   = skid_meta_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_imm_d   = core_imm;
        out_meta_d  = core_meta;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept && (SKID != 0)) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = core_imm;
      skid_meta_d  = core_meta;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_meta_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_meta_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_meta_q   <= out_meta_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_meta_q  <= skid_meta_d;
      ready_q      <= !skid_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_meta_q.fmt;
  assign out_iword   = out_meta_q.iword;
  assign out_illegal = out_meta_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench: RV32 stage with skid entry and RV64 stage without, sharing inputs.
module tb_imm_gen_stage;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_iword;
  logic        out_ready;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32, iw32;
  imm_fmt_e    fmt32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [31:0] iw64;
  imm_fmt_e    fmt64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .SKID(1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_iword(in_iword),
    .out_valid(vld32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_iword(iw32), .out_illegal(ill32)
  );

  imm_gen_stage #(.XLEN(64), .SKID(0)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_iword(in_iword),
    .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_iword(iw64), .out_illegal(ill64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] iw;
    logic [63:0] e32;
    logic [2:0]  f32;
    logic [63:0] e64;
    logic [2:0]  f64;
    logic        ill;
  } vec_t;

  vec_t vecs [12];

  localparam logic [31:0] ADDI1 = 32'h0010_0093;
  localparam logic [31:0] ADDI2 = 32'h0020_0093;
  localparam logic [31:0] ADDI3 = 32'h0030_0093;
  localparam logic [31:0] ADDI5 = 32'h0050_0093;
  localparam logic [31:0] ADDI7 = 32'h0070_0093;

  initial begin
    vecs[0]  = '{32'hFFF00093, 64'hFFFFFFFF, 3'd1, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'h800000B7, 64'h80000000, 3'd4, 64'hFFFFFFFF_80000000, 3'd4, 1'b0};
    vecs[2]  = '{32'hFE20AE23, 64'hFFFFFFFC, 3'd2, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0};
    vecs[3]  = '{32'h4030D093, 64'h00000003, 3'd7, 64'h3, 3'd7, 1'b0};
    vecs[4]  = '{32'h3002D073, 64'h00000005, 3'd6, 64'h5, 3'd6, 1'b0};
    vecs[5]  = '{32'h30001073, 64'h00000300, 3'd1, 64'h300, 3'd1, 1'b0};
    vecs[6]  = '{32'h00000001, 64'h0, 3'd0, 64'h0, 3'd0, 1'b1};
    vecs[7]  = '{32'hFE000EE3, 64'hFFFFFFFC, 3'd3, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0};
    vecs[8]  = '{32'h0080006F, 64'h00000008, 3'd5, 64'h8, 3'd5, 1'b0};
    vecs[9]  = '{32'h0000007F, 64'h0, 3'd0, 64'h0, 3'd0, 1'b0};
    vecs[10] = '{32'h0030909B, 64'h0, 3'd0, 64'h3, 3'd7, 1'b0};
    vecs[11] = '{32'h02109093, 64'h00000001, 3'd7, 64'h21, 3'd7, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_iword = '0; out_ready = 1'b1;
    #1;
    check("rst_vld32", 64'(vld32), 64'd0);
    check("rst_imm32", 64'(imm32), 64'd0);
    check("rst_fmt32", 64'(fmt32), 64'd0);
    check("rst_iw32", 64'(iw32), 64'd0);
    check("rst_ill32", 64'(ill32), 64'd0);
    check("rst_vld64", 64'(vld64), 64'd0);
    check("rst_imm64", imm64, 64'd0);
    step(); step();
    rst = 1'b0;
    step();
    check("post_rst_rdy32", 64'(rdy32), 64'd1);
    check("post_rst_rdy64", 64'(rdy64), 64'd1);

    // Back-to-back decode vectors, one-cycle latency.
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_iword = vecs[i].iw;
      step();
      check($sformatf("v%0d_vld32", i), 64'(vld32), 64'd1);
      check($sformatf("v%0d_imm32", i), 64'(imm32), vecs[i].e32);
      check($sformatf("v%0d_fmt32", i), 64'(fmt32), 64'(vecs[i].f32));
      check($sformatf("v%0d_ill32", i), 64'(ill32), 64'(vecs[i].ill));
      check($sformatf("v%0d_iw32", i), 64'(iw32), 64'(vecs[i].iw));
      check($sformatf("v%0d_vld64", i), 64'(vld64), 64'd1);
      check($sformatf("v%0d_imm64", i), imm64, vecs[i].e64);
      check($sformatf("v%0d_fmt64", i), 64'(fmt64), 64'(vecs[i].f64));
    end
    in_valid = 1'b0;
    step();
    check("idle_vld32", 64'(vld32), 64'd0);

    // Backpressure: A held, B in skid, C refused, then in-order drain.
    out_ready = 1'b0; in_valid = 1'b1; in_iword = ADDI1;
    step();
    check("skid_a_vld", 64'(vld32), 64'd1);
    check("skid_a_imm", 64'(imm32), 64'd1);
    check("skid_a_rdy32", 64'(rdy32), 64'd1);
    check("noskid_rdy64", 64'(rdy64), 64'd0);
    in_iword = ADDI2;
    step();
    check("skid_b_hold", 64'(imm32), 64'd1);
    check("skid_b_rdy", 64'(rdy32), 64'd0);
    in_iword = ADDI3;
    step();
    check("skid_c_hold", 64'(imm32), 64'd1);
    check("skid_c_iw", 64'(iw32), 64'(ADDI1));
    check("skid_c_rdy", 64'(rdy32), 64'd0);
    out_ready = 1'b1;
    check("drain_a", 64'(imm32), 64'd1);
    step();
    check("drain_b_vld", 64'(vld32), 64'd1);
    check("drain_b", 64'(imm32), 64'd2);
    check("drain_b_rdy", 64'(rdy32), 64'd1);
    step();
    in_valid = 1'b0;
    check("drain_c_vld", 64'(vld32), 64'd1);
    check("drain_c", 64'(imm32), 64'd3);
    step();
    check("drain_empty", 64'(vld32), 64'd0);

    // Flush wins over a simultaneous input handshake.
    out_ready = 1'b0; in_valid = 1'b1; in_iword = ADDI5;
    step();
    check("fl_prime", 64'(vld32), 64'd1);
    flush = 1'b1; in_iword = ADDI7;
    check("fl_rdy_before", 64'(rdy32), 64'd1);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_vld32", 64'(vld32), 64'd0);
    check("fl_vld64", 64'(vld64), 64'd0);
    check("fl_rdy32", 64'(rdy32), 64'd1);
    step();
    check("fl_nothing32", 64'(vld32), 64'd0);
    check("fl_nothing64", 64'(vld64), 64'd0);

    // Async reset mid-cycle with output and skid both occupied.
    out_ready = 1'b0; in_valid = 1'b1; in_iword = ADDI1;
    step();
    in_iword = ADDI2;
    step();
    check("pre_rst_vld", 64'(vld32), 64'd1);
    check("pre_rst_full", 64'(rdy32), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_vld32", 64'(vld32), 64'd0);
    check("arst_imm32", 64'(imm32), 64'd0);
    check("arst_iw32", 64'(iw32), 64'd0);
    check("arst_fmt32", 64'(fmt32), 64'd0);
    check("arst_vld64", 64'(vld64), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step();
    check("arst_rdy32", 64'(rdy32), 64'd1);
    check("arst_rdy64", 64'(rdy64), 64'd1);
    check("arst_idle", 64'(vld32), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
